// File: rtl/ttm4_clk_pkg.sv
// Shared constants for the TTM4 clock/step controller: mode codes, FSM states
// and board-rate default dividers.
package ttm4_clk_pkg;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_SLOW = 2'b01;
    localparam logic [1:0] MODE_FAST = 2'b10;
    localparam logic [1:0] MODE_STEP = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN_HI  = 3'd1,
        S_RUN_LO  = 3'd2,
        S_STEP_HI = 3'd3,
        S_STEP_LO = 3'd4
    } state_e;

    localparam int DEF_SLOW_DIV  = 25000000;
    localparam int DEF_FAST_DIV  = 2500000;
    localparam int DEF_DB_CYCLES = 500000;

    function automatic logic is_run_mode(input logic [1:0] m);
        return (m == MODE_SLOW) || (m == MODE_FAST);
    endfunction

endpackage

// File: rtl/ttm4_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter, and a
// one-cycle press pulse when the accepted level falls from 1 to 0.
module ttm4_debounce
    import ttm4_clk_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_n_i,
    output logic press_o
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // Any sample that agrees with the accepted level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
                press_d = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_n_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/ttm4_clock_ctrl.sv
// CPU clock generator for the TTM4 core: halt, slow/fast free-run and
// debounced single-step, with a TICK enable on every CPU_CK rising edge.
module ttm4_clock_ctrl
    import ttm4_clk_pkg::*;
#(
    parameter int SLOW_DIV  = DEF_SLOW_DIV,
    parameter int FAST_DIV  = DEF_FAST_DIV,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic       CLK,
    input  logic       nCLR,
    input  logic [1:0] MODE,
    input  logic       nSTEP_BTN,
    input  logic       HALT_REQ,
    output logic       CPU_CK,
    output logic       TICK,
    output logic       RUNNING,
    output logic       STEP_BUSY
);

    localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int PW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
    localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_DIV - 1);
    localparam logic [PW-1:0] FAST_LAST = PW'(FAST_DIV - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          slow_q, slow_d;
    logic          ck_q, ck_d;
    logic          tick_q, tick_d;
    logic          run_q, run_d;
    logic          busy_q, busy_d;
    logic          press;
    logic          phase_end;
    logic          run_ok;

    ttm4_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
        .clk_i   (CLK),
        .rst_n_i (nCLR),
        .btn_n_i (nSTEP_BTN),
        .press_o (press)
    );

    // slow_q selects the divider for the phase in progress; it is only
    // reloaded on a state change so a MODE edit never stretches or cuts a phase.
    assign phase_end = (pre_q == (slow_q ? SLOW_LAST : FAST_LAST));
    assign run_ok    = is_run_mode(MODE) && !HALT_REQ;

    always_comb begin
        state_d = state_q;
        slow_d  = slow_q;
        case (state_q)
            S_IDLE: begin
                if (run_ok) begin
                    state_d = S_RUN_HI;
                    slow_d  = (MODE == MODE_SLOW);
                end else if (MODE == MODE_STEP && press) begin
                    state_d = S_STEP_HI;
                    slow_d  = 1'b0;
                end
            end
            S_RUN_HI: begin
                if (phase_end) begin
                    state_d = S_RUN_LO;
                    if (MODE == MODE_SLOW)      slow_d = 1'b1;
                    else if (MODE == MODE_FAST) slow_d = 1'b0;
                end
            end
            S_RUN_LO: begin
                if (phase_end) begin
                    if (run_ok) begin
                        state_d = S_RUN_HI;
                        slow_d  = (MODE == MODE_SLOW);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_STEP_HI: if (phase_end) state_d = S_STEP_LO;
            S_STEP_LO: if (phase_end) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (state_d != state_q || state_q == S_IDLE || phase_end) pre_d = '0;
        else                                                      pre_d = pre_q + 1'b1;

        // Outputs are decoded from the next state and registered, so CPU_CK
        // and TICK change on the same CLK edge and never glitch.
        ck_d   = (state_d == S_RUN_HI) || (state_d == S_STEP_HI);
        tick_d = ck_d && (state_d != state_q);
        run_d  = (state_d == S_RUN_HI) || (state_d == S_RUN_LO);
        busy_d = (state_d == S_STEP_HI) || (state_d == S_STEP_LO);
    end

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            slow_q  <= 1'b0;
            ck_q    <= 1'b0;
            tick_q  <= 1'b0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            slow_q  <= slow_d;
            ck_q    <= ck_d;
            tick_q  <= tick_d;
            run_q   <= run_d;
            busy_q  <= busy_d;
        end
    end

    assign CPU_CK    = ck_q;
    assign TICK      = tick_q;
    assign RUNNING   = run_q;
    assign STEP_BUSY = busy_q;

endmodule

// File: doc/ttm4_clock_ctrl.md
Name: ttm4_clock_ctrl

Overview:
- Clock/step controller directly upstream of the TTM4 CPU core's 74HC161-style counters (PC, registers).
- Derives the CPU clock CPU_CK from the 50 MHz board clock in three modes: halt, slow/fast free-run, and manual single-step from a debounced push button.
- Provides a one-board-cycle TICK enable aligned to each CPU_CK rising edge, for display and trace logic.

Parameters:
- SLOW_DIV, 25000000, board cycles per CPU_CK half-period in slow mode (1 Hz).
- FAST_DIV, 2500000, board cycles per CPU_CK half-period in fast mode (10 Hz); also the half-period of a manual step pulse.
- DB_CYCLES, 500000, consecutive stable samples required to accept a new button level (10 ms).

Ports:
- CLK  in  1  board clock, 50 MHz.
- nCLR  in  1  reset; asynchronous, active-low.
- MODE  in  2  00 = halt, 01 = slow run, 10 = fast run, 11 = manual step.
- nSTEP_BTN  in  1  raw push button, active-low, asynchronous to CLK.
- HALT_REQ  in  1  level stop request from the CPU (e.g. HLT decode), synchronous to CLK.
- CPU_CK  out  1  CPU clock, drives CK of the downstream counters.
- TICK  out  1  one-CLK pulse in the CLK cycle where CPU_CK goes 0 to 1.
- RUNNING  out  1  1 while free-running (slow or fast).
- STEP_BUSY  out  1  1 while a manual step pulse is in progress.

Behaviour:
- Reset (nCLR = 0), asynchronous: all flops cleared.
  - CPU_CK = 0, TICK = 0, RUNNING = 0, STEP_BUSY = 0.
  - State S_IDLE, prescaler = 0, debounced button level = 1 (released), synchronizer = 11.
- Button path:
  - 2-flop synchronizer, then debounce counter.
  - Debounced level changes only after DB_CYCLES consecutive CLK samples differ from it.
  - Any glitch restarts the count.
  - Press event = debounced level 1 to 0, one CLK pulse.
- Prescaler: counts 0..DIV-1 and raises a phase-end strobe at DIV-1.
  - DIV = SLOW_DIV in mode 01, FAST_DIV in modes 10 and 11.
  - Cleared on every state transition.
- FSM states: S_IDLE, S_RUN_HI, S_RUN_LO, S_STEP_HI, S_STEP_LO.
- S_IDLE: CPU_CK = 0.
  - Goes to S_RUN_HI if MODE is 01 or 10 and HALT_REQ = 0.
  - Goes to S_STEP_HI on a press event if MODE = 11.
  - Press events in other modes are discarded.
- S_RUN_HI: CPU_CK = 1. Goes to S_RUN_LO at phase end.
- S_RUN_LO: CPU_CK = 0. At phase end:
  - to S_RUN_HI if MODE is still 01 or 10 and HALT_REQ = 0;
  - otherwise to S_IDLE.
- S_STEP_HI and S_STEP_LO: one full FAST_DIV high / FAST_DIV low period, then S_IDLE.
  - STEP_BUSY = 1 in both states.
  - Press events during a step are discarded (no queuing).
- TICK:
  - asserted in the CLK cycle after entry into S_RUN_HI or S_STEP_HI (coincident with CPU_CK rising);
  - never asserted twice per CPU_CK period.
- RUNNING = 1 in S_RUN_HI and S_RUN_LO.
- Mode change mid-period:
  - never truncates a high phase;
  - takes effect at the next S_RUN_LO phase end, so a high pulse is always exactly DIV cycles.
  - A DIV change (01 to 10) while in a phase takes effect from the next phase.
- HALT_REQ asserted during S_RUN_HI: the current period completes, then S_IDLE.
- HALT_REQ has no effect on manual steps.
- Glitch-free: CPU_CK is a registered output only, with no combinational gating.
- Counter widths are sized by $clog2 of the largest parameter. Prescaler compare uses equality, with no wrap.

Decomposition:
- Package ttm4_clk_pkg:
  - MODE_HALT/MODE_SLOW/MODE_FAST/MODE_STEP constants;
  - FSM state encoding constants;
  - default divider values.
- Sub-module ttm4_debounce (synchronizer + debounce counter + press-edge output, parameter DB_CYCLES), reusable for the reset button.

Test Plan (SLOW_DIV=8, FAST_DIV=2, DB_CYCLES=4):
- Hold nCLR = 0 with MODE=01 for 20 cycles -> CPU_CK, TICK, RUNNING, STEP_BUSY all 0. Release -> first CPU_CK rise 1 cycle later; high 8 / low 8 cycles; one TICK per rise.
- MODE=10 -> CPU_CK period 4 cycles. Switch to 00 while CPU_CK=1 -> high phase stays 2 cycles, low 2 cycles, then held 0; RUNNING falls at S_IDLE.
- MODE=11, nSTEP_BTN low for 10 cycles with 1-cycle bounces at the start -> exactly one CPU_CK pulse (2 high / 2 low), one TICK, STEP_BUSY=1 for 4 cycles.
- MODE=11, second press during STEP_BUSY -> ignored; a press shorter than 4 cycles -> no pulse.
- MODE=01, HALT_REQ=1 mid high phase -> period completes (8 low cycles), then CPU_CK stays 0. HALT_REQ=0 -> restart.
- Assert nCLR=0 mid S_RUN_HI, asynchronously between CLK edges -> CPU_CK drops to 0 immediately, no TICK; state S_IDLE.
